// File: rtl/rtu_seq_pkg.sv
// rtu_seq_pkg: shared sizing, state encoding and program-entry layout for the rtu2 sequencer
//   Entry layout: {ab[1:0], exp[2:0]} = {a,b,p,m,n}, AB_MSB=4, EXP_MSB=2.
package rtu_seq_pkg;
  localparam int SEQ_DEPTH = 8;
  localparam int SEQ_AW = 3;
  localparam int ENT_W = 5;
  localparam int AB_MSB = 4;
  localparam int EXP_MSB = 2;
  typedef enum logic [1:0] {S_IDLE, S_RST, S_RUN, S_DONE} seq_state_t;
  function automatic logic [ENT_W-1:0] mk_entry(input logic [1:0] ab, input logic [2:0] ex);
    return {ab, ex};
  endfunction
endpackage

// File: rtl/rtu_seq_mem.sv
// rtu_seq_mem: DEPTH x ENT_W program register file, synchronous write, asynchronous read
//   clk      clock, rising edge
//   i_we     write strobe
//   i_waddr  write address
//   i_wdata  entry to store
//   i_raddr  read address
//   o_rdata  entry at i_raddr (combinational)
module rtu_seq_mem import rtu_seq_pkg::*; #(
  parameter int DEPTH = SEQ_DEPTH,
  parameter int AW = SEQ_AW
) (
  input  logic             clk,
  input  logic             i_we,
  input  logic [AW-1:0]    i_waddr,
  input  logic [ENT_W-1:0] i_wdata,
  input  logic [AW-1:0]    i_raddr,
  output logic [ENT_W-1:0] o_rdata
);
  logic [ENT_W-1:0] r_mem [DEPTH];
  always_ff @(posedge clk)
    if (i_we) r_mem[i_waddr] <= i_wdata;
  assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/rtu_seq_ctrl.sv
// rtu_seq_ctrl: plays a stored {a,b} program into the rtu2 FSM and checks its {p,m,n} responses
//   Program port : prog_we, prog_addr, prog_ab, prog_exp (ignored while busy)
//   Run control  : len, start in; busy, done out
//   Results      : pass, err_idx, err_cnt (held until the next accepted start)
//   FSM side     : fsm_rst_b, fsm_a, fsm_b out; fsm_p, fsm_m, fsm_n in
//   Option macro : RTU_SEQ_STOP_ON_ERR_EN ends the run at the first mismatch
module rtu_seq_ctrl import rtu_seq_pkg::*; #(
  parameter int DEPTH = SEQ_DEPTH,
  parameter int AW = SEQ_AW
) (
  input  logic          clk,
  input  logic          rst_b,
  input  logic          prog_we,
  input  logic [AW-1:0] prog_addr,
  input  logic [1:0]    prog_ab,
  input  logic [2:0]    prog_exp,
  input  logic [AW:0]   len,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic          pass,
  output logic [AW-1:0] err_idx,
  output logic [AW:0]   err_cnt,
  output logic          fsm_rst_b,
  output logic          fsm_a,
  output logic          fsm_b,
  input  logic          fsm_p,
  input  logic          fsm_m,
  input  logic          fsm_n
);
`ifdef RTU_SEQ_STOP_ON_ERR_EN
  localparam bit STOP_ON_ERR = 1'b1;
`else
  localparam bit STOP_ON_ERR = 1'b0;
`endif
  localparam logic [AW:0] LEN_MAX = (AW+1)'(DEPTH);
  seq_state_t r_state;
  logic [AW-1:0] r_k, r_lst, r_err_idx, w_raddr;
  logic [AW:0] r_err_cnt, w_len_c;
  logic [2:0] r_exp;
  logic r_busy, r_done, r_pass, r_fsm_rst_b, r_a, r_b;
  logic [ENT_W-1:0] w_rd;
  logic w_mis, w_end;
  assign w_len_c = (len > LEN_MAX) ? LEN_MAX : len;
  // RST fetches entry 0; each RUN cycle prefetches the entry to drive next
  assign w_raddr = (r_state == S_RUN) ? r_k + AW'(1) : '0;
  // the FSM is Mealy, so its response to the driven symbol is valid this cycle
  assign w_mis = {fsm_p, fsm_m, fsm_n} != r_exp;
  assign w_end = (r_k == r_lst) || (STOP_ON_ERR && w_mis);
  rtu_seq_mem #(.DEPTH(DEPTH), .AW(AW)) u_mem (
    .clk    (clk),
    .i_we   (prog_we && !r_busy),
    .i_waddr(prog_addr),
    .i_wdata(mk_entry(prog_ab, prog_exp)),
    .i_raddr(w_raddr),
    .o_rdata(w_rd)
  );
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_state <= S_IDLE;
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_pass <= 1'b0;
      r_err_idx <= '0;
      r_err_cnt <= '0;
      r_fsm_rst_b <= 1'b0;
      r_a <= 1'b0;
      r_b <= 1'b0;
      r_k <= '0;
      r_lst <= '0;
      r_exp <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_fsm_rst_b <= 1'b1;
          if (start) begin
            r_busy <= 1'b1;
            r_pass <= 1'b0;
            if (w_len_c == '0) begin
              r_err_cnt <= '0;
              r_err_idx <= '0;
              r_state <= S_DONE;
            end else begin
              r_lst <= AW'(w_len_c - (AW+1)'(1));
              r_fsm_rst_b <= 1'b0;
              r_state <= S_RST;
            end
          end
        end
        S_RST: begin
          r_fsm_rst_b <= 1'b1;
          r_err_cnt <= '0;
          r_err_idx <= '0;
          r_k <= '0;
          {r_a, r_b} <= w_rd[AB_MSB:EXP_MSB+1];
          r_exp <= w_rd[EXP_MSB:0];
          r_state <= S_RUN;
        end
        S_RUN: begin
          if (w_mis) begin
            r_err_cnt <= (r_err_cnt == LEN_MAX) ? r_err_cnt : r_err_cnt + (AW+1)'(1);
            if (r_err_cnt == '0) r_err_idx <= r_k;
          end
          if (w_end) begin
            {r_a, r_b} <= 2'b00;
            r_state <= S_DONE;
          end else begin
            r_k <= r_k + AW'(1);
            {r_a, r_b} <= w_rd[AB_MSB:EXP_MSB+1];
            r_exp <= w_rd[EXP_MSB:0];
          end
        end
        S_DONE: begin
          r_done <= 1'b1;
          r_busy <= 1'b0;
          r_pass <= (r_err_cnt == '0);
          {r_a, r_b} <= 2'b00;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
  assign busy = r_busy;
  assign done = r_done;
  assign pass = r_pass;
  assign err_idx = r_err_idx;
  assign err_cnt = r_err_cnt;
  assign fsm_rst_b = r_fsm_rst_b;
  assign fsm_a = r_a;
  assign fsm_b = r_b;
endmodule
